// File: rtl/pulse_shaper.sv
// pulse_shaper: turns single-cycle trigger pulses into fixed-width high pulses, each followed by a guaranteed low gap.
// Optional trigger queueing is enabled by defining PULSE_SHAPER_QUEUE_EN; without it, early triggers are dropped.
module pulse_shaper #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              trig,
    input  logic [CNT_W-1:0]  hi_len,
    input  logic [CNT_W-1:0]  lo_len,
    output logic              dout,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // A zero length is treated as one cycle, so the counter reload is max(len,1)-1.
    function automatic logic [CNT_W-1:0] len_load(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] res;
        if (len == {CNT_W{1'b0}}) begin
            res = {CNT_W{1'b0}};
        end else begin
            res = len - CNT_W'(1);
        end
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   lo_lat_q, lo_lat_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic               cnt_zero_s;
    logic               last_gap_s;
    logic               queue_req_s;
    logic               pend_nz_s;

    assign cnt_zero_s  = (cnt_q == {CNT_W{1'b0}});
    assign last_gap_s  = (state_q == ST_GAP) && cnt_zero_s;
    assign queue_req_s = trig && ((state_q == ST_HIGH) || ((state_q == ST_GAP) && !cnt_zero_s));

`ifdef PULSE_SHAPER_QUEUE_EN
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               pend_full_s;

    assign pend_nz_s   = (pend_q != {PEND_W{1'b0}});
    assign pend_full_s = (pend_q == {PEND_W{1'b1}});
    assign pend        = pend_q;
`else
    assign pend_nz_s   = 1'b0;
    assign pend        = {PEND_W{1'b0}};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and length-latch logic; a start event loads hi and captures lo together.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_lat_d = lo_lat_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d  = ST_HIGH;
                    cnt_d    = len_load(hi_len);
                    lo_lat_d = lo_len;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (cnt_zero_s) begin
                    state_d = ST_GAP;
                    cnt_d   = len_load(lo_lat_q);
                end else begin
                    state_d = ST_HIGH;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (!cnt_zero_s) begin
                    state_d = ST_GAP;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else if (pend_nz_s || trig) begin
                    state_d  = ST_HIGH;
                    cnt_d    = len_load(hi_len);
                    lo_lat_d = lo_len;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode plus pending-count bookkeeping for triggers that arrive while a pulse is in flight.
    always_comb begin
        dout_d = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        ovf_d  = 1'b0;
`ifdef PULSE_SHAPER_QUEUE_EN
        pend_d = pend_q;
        if (queue_req_s) begin
            if (pend_full_s) begin
                ovf_d  = 1'b1;
                pend_d = pend_q;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (last_gap_s && pend_nz_s && !trig) begin
            pend_d = pend_q - PEND_W'(1);
        end else begin
            pend_d = pend_q;
        end
`else
        if (queue_req_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = 1'b0;
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q    <= {CNT_W{1'b0}};
            lo_lat_q <= {CNT_W{1'b0}};
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef PULSE_SHAPER_QUEUE_EN
            pend_q   <= {PEND_W{1'b0}};
`endif
        end else begin
            cnt_q    <= cnt_d;
            lo_lat_q <= lo_lat_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
`ifdef PULSE_SHAPER_QUEUE_EN
            pend_q   <= pend_d;
`endif
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/pulse_shaper.md
# pulse_shaper

Regenerates a clean level waveform from single-cycle trigger pulses, for example those produced by the team's edge detectors. Each accepted trigger produces one output pulse that is high for a programmed number of cycles, followed by a guaranteed low gap. Triggers that arrive while a pulse is in progress can be queued, so downstream level-sensitive logic sees one distinct rising edge per trigger.

## Interface
Parameters:
- CNT_W, 8, width of the hi_len/lo_len length fields and the internal down-counter.
- PEND_W, 4, width of the pending-trigger counter; maximum queued triggers = 2^PEND_W-1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- resetn  in  1  reset, synchronous, active-low.
- trig  in  1  trigger request, sampled every cycle; each high cycle is one request.
- hi_len  in  CNT_W  high-phase length in cycles; 0 is treated as 1.
- lo_len  in  CNT_W  gap (low-phase) length in cycles; 0 is treated as 1.
- dout  out  1  shaped output waveform, registered.
- busy  out  1  high whenever the state is not IDLE.
- pend  out  PEND_W  number of queued triggers not yet started.
- ovf  out  1  single-cycle pulse when a trigger is dropped.

## Operation
- States: IDLE, HIGH, GAP. One down-counter cnt.
- **Reset.** Applies in the cycle resetn is low. State becomes IDLE, cnt = 0, dout = 0, busy = 0, pend = 0, ovf = 0. Reset takes effect mid-pulse and discards all queued triggers.
- **Start event.** On entering HIGH, hi_len and lo_len are latched together. cnt is loaded with max(hi_len,1)-1. Length inputs are ignored at all other times.
- **IDLE.** trig = 1 -> HIGH, dout = 1 from the next cycle.
- **HIGH.** dout = 1. cnt decrements each cycle. At cnt == 0 -> GAP, with cnt loaded from max(latched lo_len,1)-1 and dout = 0 next cycle.
- **GAP.** dout = 0. cnt decrements each cycle. At cnt == 0 the next state is chosen as follows:
  - if pend > 0 or trig = 1 -> HIGH, a new start event;
  - otherwise -> IDLE.
- **Queueing.** A trig arriving in HIGH, or in GAP with cnt != 0, increments pend.
- **Dequeue rule.** On a GAP -> HIGH transition with pend > 0, pend decrements, unless trig is also high that cycle; then pend is unchanged.
- **Final GAP cycle.** A trig in the last GAP cycle with pend == 0 starts the next pulse directly. It is not counted in pend.
- **Overflow.** A trig that would increment pend while pend == 2^PEND_W-1 is dropped. ovf = 1 the next cycle and pend holds.
- **Pulse width.** Every output pulse is exactly max(hi_len,1) cycles high, followed by at least max(lo_len,1) cycles low.
- **Arithmetic.** All length arithmetic is unsigned CNT_W bits. pend is saturating within 0..2^PEND_W-1 and never wraps.

## Timing
- **Start latency.** trig high in cycle N while IDLE -> dout high in cycles N+1 .. N+max(hi_len,1).
- **Gap placement.** The gap follows immediately after the high phase. busy is high from N+1 through the last GAP cycle.
- **busy.** Decoded from the state register; no extra latency.
- **ovf, pend.** Registered; they reflect the trig of the previous cycle.
- **Back-to-back throughput.** Consecutive pulses have period max(hi_len,1)+max(lo_len,1). No idle cycle is inserted between queued pulses.

## Configuration
- Macro: PULSE_SHAPER_QUEUE_EN.
- **Defined.** The pending counter and queueing behave as described above.
- **Undefined.**
  - No pending storage; pend is tied to 0.
  - Every trig arriving in HIGH, or in GAP with cnt != 0, is dropped with a one-cycle ovf pulse.
  - A trig in the final GAP cycle still starts the next pulse.

## Test plan
- **Reset.** Hold resetn = 0 for 3 cycles while toggling trig -> dout, busy, ovf = 0 and pend = 0 throughout. First trig after release at cycle N gives dout = 1 at N+1.
- **Single pulse.** hi_len = 3, lo_len = 2, trig at N -> dout = 1 at N+1..N+3, dout = 0 at N+4..N+5, busy = 0 from N+6.
- **Zero lengths.** hi_len = 0, lo_len = 0, trig at N and N+1 -> dout pattern 1,0,1,0 over N+1..N+4. pend goes 1 then 0.
- **Queue.** hi_len = 2, lo_len = 1, trig at N, N+1, N+2 -> dout = 1 at N+1..N+2, N+4..N+5, N+7..N+8. pend peaks at 2. ovf is never asserted.
- **Overflow.**
  - PEND_W = 2, hi_len = 10: trig high for 5 consecutive cycles.
  - Required response: pend saturates at 3, ovf pulses exactly once, and exactly 4 pulses are emitted in total.
  - With PULSE_SHAPER_QUEUE_EN undefined, the same stimulus gives 4 ovf pulses and 1 emitted pulse.
- **Mid-operation reset.** resetn = 0 for one cycle during HIGH with pend = 2 -> dout = 0 and pend = 0 on the next cycle, and no further pulses are emitted without a new trig.
